// File: rtl/alu_pkg.sv
// Shared ALU encodings: ALUCtl codes, MIPS R-type funct codes and the
// sharing controller's state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_BAD = 4'd15;

    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_NOR = 6'd39;
    localparam logic [5:0] F_SLT = 6'd42;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational MIPS R-type funct -> ALUCtl decoder; unknown codes
// map to ALU_BAD with err set.
module alu_funct_decode
    import alu_pkg::*;
#(
    parameter int FUNCT_W = 6
) (
    input  logic [FUNCT_W-1:0] funct,
    output logic [3:0]         alu_ctl,
    output logic               err
);

    always_comb begin
        alu_ctl = ALU_BAD;
        err     = 1'b0;
        case (funct)
            F_ADD:   alu_ctl = ALU_ADD;
            F_SUB:   alu_ctl = ALU_SUB;
            F_AND:   alu_ctl = ALU_AND;
            F_OR:    alu_ctl = ALU_OR;
            F_NOR:   alu_ctl = ALU_NOR;
            F_SLT:   alu_ctl = ALU_SLT;
            default: err     = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one external ALU between two requesters, with a
// registered, ID-tagged response channel.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [FUNCT_W-1:0] req_funct0,
    input  logic [FUNCT_W-1:0] req_funct1,
    input  logic [WIDTH-1:0]   req_a0,
    input  logic [WIDTH-1:0]   req_a1,
    input  logic [WIDTH-1:0]   req_b0,
    input  logic [WIDTH-1:0]   req_b1,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [3:0]         alu_ctl,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_zero
);

    state_t             state;
    logic               rr_last;
    logic               op_id;
    logic [FUNCT_W-1:0] op_funct;
    logic [3:0]         ctl_q;
    logic [3:0]         dec_ctl;
    logic               dec_err;
    logic               winner;
    logic [1:0]         grant;

    alu_funct_decode #(.FUNCT_W(FUNCT_W)) u_decode (
        .funct   (op_funct),
        .alu_ctl (dec_ctl),
        .err     (dec_err)
    );

    // Grant is gated by rst_n so req_ready drops the moment reset asserts.
    always_comb begin
        winner = req_valid[~rr_last] ? ~rr_last : rr_last;
        grant  = '0;
        if (rst_n && state == IDLE && |req_valid)
            grant[winner] = 1'b1;
    end

    assign req_ready = grant;
    // Decoded control goes straight out in EXEC; ctl_q holds it afterwards.
    assign alu_ctl   = (state == EXEC) ? dec_ctl : ctl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            op_id     <= 1'b0;
            op_funct  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            ctl_q     <= ALU_BAD;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|grant) begin
                        op_id    <= winner;
                        op_funct <= winner ? req_funct1 : req_funct0;
                        alu_a    <= winner ? req_a1 : req_a0;
                        alu_b    <= winner ? req_b1 : req_b0;
                        rr_last  <= winner;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= dec_err ? '0 : alu_out;
                    rsp_zero  <= dec_err | alu_zero;
                    rsp_err   <= dec_err;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    ctl_q     <= dec_ctl;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: behavioural ALU, transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_funct0, req_funct1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_data;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    alu_share_ctrl #(.WIDTH(32), .FUNCT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct0 (req_funct0),
        .req_funct1 (req_funct1),
        .req_a0     (req_a0),
        .req_a1     (req_a1),
        .req_b0     (req_b0),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_ctl    (alu_ctl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // External MIPS ALU; unused codes return a marker so err forcing is visible.
    always_comb begin
        case (alu_ctl)
            4'd0:    alu_out = alu_a & alu_b;
            4'd1:    alu_out = alu_a | alu_b;
            4'd2:    alu_out = alu_a + alu_b;
            4'd6:    alu_out = alu_a - alu_b;
            4'd7:    alu_out = {31'b0, alu_a < alu_b};
            4'd12:   alu_out = ~(alu_a | alu_b);
            default: alu_out = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_out == 32'h0);
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        zero;
        logic        err;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    function automatic exp_t model_op(logic id, logic [5:0] f, logic [31:0] a, logic [31:0] b);
        exp_t e;
        e.id  = id;
        e.a   = a;
        e.b   = b;
        e.err = 1'b0;
        case (f)
            6'd32:   begin e.data = a + b;          e.ctl = 4'd2;  end
            6'd34:   begin e.data = a - b;          e.ctl = 4'd6;  end
            6'd36:   begin e.data = a & b;          e.ctl = 4'd0;  end
            6'd37:   begin e.data = a | b;          e.ctl = 4'd1;  end
            6'd39:   begin e.data = ~(a | b);       e.ctl = 4'd12; end
            6'd42:   begin e.data = (a < b) ? 32'd1 : 32'd0; e.ctl = 4'd7; end
            default: begin e.data = '0; e.ctl = 4'hF; e.err = 1'b1; end
        endcase
        e.zero = e.err | (e.data == 32'h0);
        return e;
    endfunction

    // Reference model: one outstanding op, cycles counted since acceptance.
    exp_t m_q[$];
    bit   m_busy = 1'b0;
    int   m_age  = 0;
    bit   m_last = 1'b1;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_rsp_id",    32'(rsp_id),    32'h0);
            chk("rst_rsp_data",  rsp_data,       32'h0);
            chk("rst_rsp_zero",  32'(rsp_zero),  32'h0);
            chk("rst_rsp_err",   32'(rsp_err),   32'h0);
            chk("rst_alu_ctl",   32'(alu_ctl),   32'hF);
            chk("rst_alu_a",     alu_a,          32'h0);
            chk("rst_alu_b",     alu_b,          32'h0);
        end else begin
            logic [1:0] exp_ready;
            bit w;
            exp_ready = 2'b00;
            w = req_valid[!m_last] ? !m_last : m_last;
            if (!m_busy && |req_valid) exp_ready[w] = 1'b1;
            chk("m_req_ready", 32'(req_ready), 32'(exp_ready));
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 1));
            if (m_busy && m_age == 0) begin
                chk("m_alu_ctl", 32'(alu_ctl), 32'(m_q[0].ctl));
                chk("m_alu_a",   alu_a,        m_q[0].a);
                chk("m_alu_b",   alu_b,        m_q[0].b);
            end
            if (m_busy && m_age >= 1) begin
                chk("m_rsp_id",   32'(rsp_id),   32'(m_q[0].id));
                chk("m_rsp_data", rsp_data,      m_q[0].data);
                chk("m_rsp_zero", 32'(rsp_zero), 32'(m_q[0].zero));
                chk("m_rsp_err",  32'(rsp_err),  32'(m_q[0].err));
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_last = 1'b1;
            m_q.delete();
        end else if (m_busy) begin
            if (m_age >= 1 && rsp_ready) begin
                m_busy = 1'b0;
                void'(m_q.pop_front());
            end else begin
                m_age++;
            end
        end else if (|req_valid) begin
            bit w;
            w = req_valid[!m_last] ? !m_last : m_last;
            if (w) m_q.push_back(model_op(1'b1, req_funct1, req_a1, req_b1));
            else   m_q.push_back(model_op(1'b0, req_funct0, req_a0, req_b0));
            m_busy = 1'b1;
            m_age  = 0;
            m_last = w;
        end
    end

    task automatic send(input int id, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int acc);
        @(posedge clk); #2;
        if (id == 0) begin req_funct0 = f; req_a0 = a; req_b0 = b; end
        else         begin req_funct1 = f; req_a1 = a; req_b1 = b; end
        req_valid[id] = 1'b1;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin acc = cyc; break; end
        end
        chk("send_granted", 32'(acc >= 0), 32'h1);
        @(posedge clk); #2;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output logic id, output logic [31:0] d, output logic z,
                            output logic e, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin at = cyc; break; end
        end
        chk("rsp_seen", 32'(at >= 0), 32'h1);
        id = rsp_id; d = rsp_data; z = rsp_zero; e = rsp_err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_id, r_z, r_e;
        logic [31:0] r_d;
        int          acc, at, ng;
        logic [5:0]  fl [6];
        logic [31:0] el [6];
        int          g  [4];

        fl = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd39};
        el = '{32'd1, 32'd7, 32'd8, 32'd2, 32'd0, 32'hFFFFFFF8};

        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
        req_funct0 = '0; req_funct1 = '0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Single ADD on requester 0
        send(0, 6'd32, 32'd1, 32'd1, acc);
        wait_rsp(r_id, r_d, r_z, r_e, at);
        chk("add_latency", 32'(at - acc), 32'd2);
        chk("add_id",   32'(r_id), 32'd0);
        chk("add_data", r_d,       32'd2);
        chk("add_zero", 32'(r_z),  32'd0);
        chk("add_err",  32'(r_e),  32'd0);

        // All six ops on requester 1 with A=5, B=3
        for (int k = 0; k < 6; k++) begin
            send(1, fl[k], 32'd5, 32'd3, acc);
            wait_rsp(r_id, r_d, r_z, r_e, at);
            chk("op6_id",   32'(r_id), 32'd1);
            chk("op6_data", r_d,       el[k]);
            chk("op6_zero", 32'(r_z),  32'(el[k] == 32'd0));
            chk("op6_err",  32'(r_e),  32'd0);
        end
        send(1, 6'd34, 32'd3, 32'd3, acc);
        wait_rsp(r_id, r_d, r_z, r_e, at);
        chk("sub_eq_data", r_d,      32'd0);
        chk("sub_eq_zero", 32'(r_z), 32'd1);

        // Contention: both requesters held valid with stable payloads
        @(posedge clk); #2;
        req_funct0 = 6'd32; req_a0 = 32'd10;  req_b0 = 32'd20;
        req_funct1 = 6'd34; req_a1 = 32'd100; req_b1 = 32'd1;
        req_valid = 2'b11;
        ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            if (|req_ready) begin g[ng] = int'(req_ready[1]); ng++; end
        end
        chk("cont_grants", 32'(ng), 32'd4);
        @(posedge clk); #2;
        req_valid = 2'b00;
        for (int k = 0; k < 4; k++) chk("cont_order", 32'(g[k]), 32'(k % 2));
        repeat (4) @(posedge clk);

        // Backpressure: response held 10 cycles while requester 1 waits
        #2 rsp_ready = 1'b0;
        send(0, 6'd32, 32'd7, 32'd9, acc);
        req_funct1 = 6'd37; req_a1 = 32'd1; req_b1 = 32'd2;
        req_valid[1] = 1'b1;
        wait_rsp(r_id, r_d, r_z, r_e, at);
        chk("bp_data", r_d, 32'd16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data_hold", rsp_data, r_d);
            chk("bp_id_hold", 32'(rsp_id), 32'(r_id));
            chk("bp_ready_low", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #2 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        @(posedge clk); #2 req_valid[1] = 1'b0;
        wait_rsp(r_id, r_d, r_z, r_e, at);
        chk("bp_next_id",   32'(r_id), 32'd1);
        chk("bp_next_data", r_d,       32'd3);

        // Illegal funct
        send(0, 6'd0, 32'd5, 32'd5, acc);
        chk("ill_alu_ctl", 32'(alu_ctl), 32'hF);
        wait_rsp(r_id, r_d, r_z, r_e, at);
        chk("ill_err",  32'(r_e), 32'd1);
        chk("ill_data", r_d,      32'd0);
        chk("ill_zero", 32'(r_z), 32'd1);

        // Reset during EXEC of a requester-0 op
        send(0, 6'd32, 32'd2, 32'd2, acc);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready",   32'(req_ready), 32'd0);
        chk("mid_rst_valid",   32'(rsp_valid), 32'd0);
        chk("mid_rst_alu_ctl", 32'(alu_ctl),   32'hF);
        chk("mid_rst_alu_a",   alu_a,          32'd0);
        @(posedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #2;
        req_funct0 = 6'd32; req_a0 = 32'd4; req_b0 = 32'd4;
        req_funct1 = 6'd36; req_a1 = 32'd6; req_b1 = 32'd3;
        req_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_grant", 32'(req_ready), 32'h1);
        @(posedge clk); #2 req_valid = 2'b00;
        wait_rsp(r_id, r_d, r_z, r_e, at);
        chk("post_rst_id",   32'(r_id), 32'd0);
        chk("post_rst_data", r_d,       32'd8);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one MIPSALU instance between two requesters (0 = integer pipe, 1 = debug/test port) using round-robin arbitration.
- Decodes each winning request's MIPS R-type funct code into ALUCtl, drives the shared ALU, and registers its result and Zero flag.
- Returns the result on a shared response channel tagged with the requester ID.
- Sits between the issue logic and the ALU; the ALU is instantiated outside this block.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- FUNCT_W, 6, funct field width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high per cycle
- req_funct0, req_funct1  in  FUNCT_W each  funct code per requester
- req_a0, req_a1, req_b0, req_b1  in  WIDTH each  operands per requester
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that owns the response
- rsp_data  out  WIDTH  registered ALU result
- rsp_zero  out  1  registered ALU Zero flag
- rsp_err  out  1  illegal funct; rsp_data = 0
- alu_ctl  out  4  to ALU ALUCtl
- alu_a, alu_b  out  WIDTH each  to ALU operands
- alu_out  in  WIDTH  from ALU result (combinational)
- alu_zero  in  1  from ALU Zero flag

Behaviour:
- Reset is asynchronous and active-low on rst_n, with one clock clk. On reset:
  - state = IDLE; rr_last = 1, so requester 0 has priority first.
  - All of req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err are 0.
  - alu_ctl = 4'hF; alu_a = alu_b = 0.
- Decode (combinational, on the latched funct):
  - 32→2 (ADD), 34→6 (SUB), 36→0 (AND), 37→1 (OR), 39→12 (NOR), 42→7 (SLT).
  - Any other code → 15 with err = 1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant by round-robin. The winner is the requester not equal to rr_last if it is valid, else the other one.
  - req_ready[winner] = 1 combinationally in this cycle. The transfer happens on req_valid & req_ready.
  - On transfer: latch funct, A, B and id into operand registers; rr_last ← winner; go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC (exactly one cycle):
  - alu_ctl, alu_a and alu_b are driven from the latched registers, not from the requester ports.
  - At the clock edge: rsp_data ← (err ? 0 : alu_out); rsp_zero ← (err ? 1 : alu_zero); rsp_err ← err; rsp_id ← id; rsp_valid ← 1; go to RESP.
- RESP:
  - Hold all rsp_* outputs stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid ← 0; go to IDLE.
  - req_ready is 0 throughout EXEC and RESP.
- Latency and throughput:
  - Request accept to rsp_valid = 2 clock edges (accept edge, EXEC edge).
  - Maximum throughput is one operation per 3 cycles with rsp_ready held high.
- Holding alu_ctl: the ALU control is driven only in EXEC. alu_ctl stays at its last value outside EXEC; no constraint is placed on it in IDLE or RESP.
- Simultaneous requests: the loser keeps its request asserted and must keep its payload stable. It is guaranteed the grant at the next IDLE (round-robin, no starvation).
- Request deasserted: a requester dropping req_valid before the grant is legal and loses nothing.
- Reset mid-operation: an operation in flight in EXEC or RESP is discarded with no response. rr_last returns to 1.
- Arithmetic: SLT is unsigned, as the ALU implements it. ADD/SUB wrap modulo 2^WIDTH and produce no overflow flag.

Decomposition:
- Shared package alu_pkg holds:
  - ALUCtl localparams: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_BAD=15.
  - Funct localparams: F_ADD=32, F_SUB=34, F_AND=36, F_OR=37, F_NOR=39, F_SLT=42.
  - FSM state encoding.
- One sub-module: alu_funct_decode, a combinational funct → {ALUCtl, err} decoder. It replaces the commented-out ALUControl and is reusable by the single-cycle datapath.

Test Plan:
- Single ADD: requester 0, funct 32, A=1, B=1 → req_ready0 high in the same cycle; 2 edges later rsp_valid=1, rsp_id=0, rsp_data=2, rsp_zero=0, rsp_err=0.
- All six ops on requester 1, A=5, B=3:
  - AND=1, OR=7, ADD=8, SUB=2, SLT=0, NOR=FFFFFFF8.
  - SUB with A=B=3 → rsp_data=0, rsp_zero=1.
- Contention: both requesters valid continuously with rsp_ready=1 → grants alternate 0,1,0,1; each response id matches its operands; neither requester starves.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid → rsp_* stable and req_ready=0 for all 10 cycles; rsp_ready=1 → response retires and IDLE accepts the next request in the following cycle.
- Illegal funct 0 → alu_ctl=15, rsp_err=1, rsp_data=0, rsp_zero=1.
- Reset mid-op: rst_n low during EXEC → all outputs 0 and alu_ctl=F immediately (asynchronously), no response after release, first grant goes to requester 0.
